alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one alu instance among NUM_REQ requesters (execute stage, branch-compare
//  unit, debug port, ...). Round-robin grant, valid/ready on both sides, one
//  registered result slot tagged with the requester id. Rejects fn codes the alu
//  leaves undefined.
// PARAMETERS
//  NUM_REQ  4  number of requesters, >=2
//  ID_W     $clog2(NUM_REQ)  localparam, width of rsp_id
// PORTS
//  clk        in   1           clock, all state on rising edge
//  rst_n      in   1           asynchronous reset, active-low
//  req_valid  in   NUM_REQ     request i presents an operation
//  req_fn     in   6*NUM_REQ   alu fn of requester i, slice [6i+5:6i]
//  req_a      in   32*NUM_REQ  operand a of requester i
//  req_b      in   32*NUM_REQ  operand b of requester i
//  req_ready  out  NUM_REQ     one-hot grant, request i accepted this cycle
//  rsp_valid  out  1           result slot full
//  rsp_ready  in   1           consumer takes result
//  rsp_y      out  32          alu result
//  rsp_id     out  ID_W        index of the requester that issued it
//  rsp_err    out  1           fn was illegal, rsp_y forced to 0
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_y=0, rsp_id=0, rsp_err=0, rr pointer=0; req_ready=0.
//  slot_free = !rsp_valid | rsp_ready. Arbitration only when slot_free.
//  Grant: first i with req_valid[i], scanning ptr, ptr+1, .., wrapping modulo
//   NUM_REQ. req_ready[g]=1 only for grant g, at most one bit set, combinational
//   from req_valid, ptr and slot state. No grant when no req_valid.
//  On grant: ptr <= (g==NUM_REQ-1) ? 0 : g+1. No grant leaves ptr unchanged.
//  Operands of g go straight to the alu; result is registered: rsp_valid=1, rsp_y,
//   rsp_id=g, rsp_err on the next edge. Latency 1 cycle. Throughput 1/cycle
//   while rsp_ready=1.
//  rsp_valid & !rsp_ready: slot, rsp_* held stable, req_ready all 0.
//  Simultaneous drain and grant: old result leaves, new result loads same edge.
//  Drain without grant: rsp_valid <= 0; rsp_y/id/err keep their values.
//  Illegal fn, still accepted: fn[5:4]=00 with fn[2:1]=00, or fn[5:4]=11 with
//   fn[1:0]=10. rsp_err=1, rsp_y=0. Never passes alu X into the slot.
//  Requesters must hold req_* stable until req_ready. A dropped req_valid
//   just loses arbitration, no error.
//  Reset mid-operation: pending result discarded, ptr=0; no response ever
//   issued for a request accepted before reset.
// STRUCTURE
//  beta_alu_pkg: fn encodings (ADD 010000, SUB 010001, CMPEQ 000011,
//   CMPLT 000101, CMPLE 000111, AND 101000, OR 101110, XOR 100110, SHL 110000,
//   SHR 110001, SRA 110011) and the fn_illegal function.
//  Sub-module rr_arbiter (parameter N): req vector, enable -> one-hot grant, index,
//   owns the pointer. alu_arbiter instantiates rr_arbiter, the operand mux, alu
//   and the result register.
// TESTING
//  1 Single req0 ADD a=3 b=4, rsp_ready=1 -> next cycle rsp_valid=1 y=7 id=0 err=0.
//  2 All 4 valid every cycle, rsp_ready=1 -> grants 0,1,2,3,0,..; ids same order.
//  3 req1 SUB 5-7 accepted, rsp_ready=0 for 3 cycles -> req_ready=0, y=0xFFFFFFFE
//    held stable; rsp_ready=1 -> same-cycle grant of next req, new result next edge.
//  4 req2 fn=000000 and fn=110010 -> err=1 y=0; CMPLT a=0xFFFFFFFF b=1 -> y=1.
//  5 ptr=3, only req1 valid -> grant 1, ptr=2; then req0+req3 valid -> grant 3.
//  6 rst_n low while rsp_valid=1 and req pending -> outputs 0 at once; after
//    release first grant goes to lowest valid index from ptr=0.

Source files
------------

// File: rtl/beta_alu_pkg.sv
// rtl/beta_alu_pkg.sv - alu function encodings, unit decode and illegal-fn check
package beta_alu_pkg;

    localparam logic [5:0] FN_ADD   = 6'b010000;
    localparam logic [5:0] FN_SUB   = 6'b010001;
    localparam logic [5:0] FN_CMPEQ = 6'b000011;
    localparam logic [5:0] FN_CMPLT = 6'b000101;
    localparam logic [5:0] FN_CMPLE = 6'b000111;
    localparam logic [5:0] FN_AND   = 6'b101000;
    localparam logic [5:0] FN_OR    = 6'b101110;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_SHL   = 6'b110000;
    localparam logic [5:0] FN_SHR   = 6'b110001;
    localparam logic [5:0] FN_SRA   = 6'b110011;

    // fn[5:4] selects the functional unit inside the alu
    typedef enum logic [1:0] {
        UNIT_CMP   = 2'b00,
        UNIT_ARITH = 2'b01,
        UNIT_BOOL  = 2'b10,
        UNIT_SHIFT = 2'b11
    } alu_unit_e;

    // Compare with no condition selected, or shift with fn[1:0]=10, has no defined result
    function automatic logic fn_illegal(input logic [5:0] fn);
        return ((fn[5:4] == 2'b00) && (fn[2:1] == 2'b00)) ||
               ((fn[5:4] == 2'b11) && (fn[1:0] == 2'b10));
    endfunction

endpackage

// File: rtl/beta_alu.sv
// rtl/beta_alu.sv - combinational beta alu: compare, add/sub, boolean table, shifts
module beta_alu
    import beta_alu_pkg::*;
(
    input  logic [5:0]  fn_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);

    alu_unit_e   unit;
    logic [31:0] b_eff;
    logic [31:0] sum;
    logic [3:0]  tt;
    logic [4:0]  sh;

    assign unit  = alu_unit_e'(fn_i[5:4]);
    // fn[0] turns the adder into a subtractor (two's complement of b)
    assign b_eff = fn_i[0] ? ~b_i : b_i;
    assign sum   = a_i + b_eff + {31'd0, fn_i[0]};
    assign tt    = fn_i[3:0];
    assign sh    = b_i[4:0];

    // Unit select; undefined sub-codes yield 0 rather than X
    always_comb begin
        y_o = '0;
        unique case (unit)
            UNIT_ARITH: y_o = sum;
            UNIT_CMP: begin
                case (fn_i[2:1])
                    2'b01:   y_o = {31'd0, a_i == b_i};
                    2'b10:   y_o = {31'd0, $signed(a_i) < $signed(b_i)};
                    2'b11:   y_o = {31'd0, $signed(a_i) <= $signed(b_i)};
                    default: y_o = '0;
                endcase
            end
            UNIT_BOOL: begin
                // fn[3:0] is a truth table indexed by {b, a}
                for (int i = 0; i < 32; i++) begin
                    y_o[i] = tt[{b_i[i], a_i[i]}];
                end
            end
            UNIT_SHIFT: begin
                case (fn_i[1:0])
                    2'b00:   y_o = a_i << sh;
                    2'b01:   y_o = a_i >> sh;
                    2'b11:   y_o = $unsigned($signed(a_i) >>> sh);
                    default: y_o = '0;
                endcase
            end
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter owning the rotating priority pointer
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [N-1:0]  req_eff;

    assign req_eff = en_i ? req_i : '0;

    // Scan from ptr upward with wrap; first requester found wins
    always_comb begin
        int            c;
        logic [IW-1:0] c_idx;
        c       = 0;
        c_idx   = '0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr_q) + k;
            if (c >= N) begin
                c = c - N;
            end
            c_idx = IW'(c);
            if (!valid_o && req_eff[c_idx]) begin
                valid_o      = 1'b1;
                gnt_o[c_idx] = 1'b1;
                idx_o        = c_idx;
            end
        end
    end

    // Pointer moves to just past the winner; idle cycles leave it alone
    always_comb begin
        ptr_d = ptr_q;
        if (valid_o) begin
            ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one alu among NUM_REQ requesters with a tagged result slot
module alu_arbiter
    import beta_alu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [6*NUM_REQ-1:0]  req_fn,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_y,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_err
);

    logic               rsp_valid_q;
    logic [31:0]        rsp_y_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic               rsp_err_q;

    logic               slot_free;
    logic               arb_en;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_valid;

    logic [5:0]         fn_sel;
    logic [31:0]        a_sel;
    logic [31:0]        b_sel;
    logic [31:0]        alu_y;
    logic               sel_err;
    logic [31:0]        y_d;

    // The slot can take a new result when empty or being drained this cycle;
    // reset also blocks grants so req_ready reads 0 while rst_n is low.
    assign slot_free = !rsp_valid_q || rsp_ready;
    assign arb_en    = slot_free && rst_n;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_valid),
        .en_i    (arb_en),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_valid)
    );

    assign req_ready = gnt;

    // Operand mux: route the winner's fn and operands to the alu
    always_comb begin
        fn_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                fn_sel = req_fn[6*i +: 6];
                a_sel  = req_a[32*i +: 32];
                b_sel  = req_b[32*i +: 32];
            end
        end
    end

    beta_alu u_alu (
        .fn_i (fn_sel),
        .a_i  (a_sel),
        .b_i  (b_sel),
        .y_o  (alu_y)
    );

    // Illegal codes are still accepted but report err with a clean zero result
    assign sel_err = fn_illegal(fn_sel);
    assign y_d     = sel_err ? '0 : alu_y;

    // Result slot: load on grant, empty on drain-only, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else if (gnt_valid) begin
            rsp_valid_q <= 1'b1;
            rsp_y_q     <= y_d;
            rsp_id_q    <= gnt_idx;
            rsp_err_q   <= sel_err;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [6*N-1:0]  req_fn = '0;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [31:0]     rsp_y;
    logic [1:0]      rsp_id;
    logic            rsp_err;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_fn    (req_fn),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] y;
        int          id;
        logic        err;
    } exp_t;

    typedef struct {
        int          id;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        err;
    } vec_t;

    exp_t exp_q[$];
    int   gnt_log[$];
    vec_t vt[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int id, input logic [5:0] fn,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        e.y   = '0;
        casez (fn)
            6'b00?00?, 6'b11??10: e.err = 1'b1;
            6'b010000: e.y = a + b;
            6'b010001: e.y = a - b;
            6'b000011: e.y = {31'd0, a == b};
            6'b000101: e.y = {31'd0, $signed(a) < $signed(b)};
            6'b000111: e.y = {31'd0, $signed(a) <= $signed(b)};
            6'b101000: e.y = a & b;
            6'b101110: e.y = a | b;
            6'b100110: e.y = a ^ b;
            6'b110000: e.y = a << b[4:0];
            6'b110001: e.y = a >> b[4:0];
            6'b110011: e.y = $unsigned($signed(a) >>> b[4:0]);
            default:   e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard: pop on every handshake, push the model result for every grant
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_empty: unexpected response id %0d y %h", rsp_id, rsp_y);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_y", rsp_y, e.y);
                    check("sb_id", {30'd0, rsp_id}, e.id);
                    check("sb_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
            if (req_ready != '0) begin
                check("onehot", {31'd0, $onehot(req_ready)}, 32'd1);
                for (int g = 0; g < N; g++) begin
                    if (req_ready[g]) begin
                        exp_q.push_back(model(g, req_fn[6*g +: 6], req_a[32*g +: 32], req_b[32*g +: 32]));
                        gnt_log.push_back(g);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        req_fn[6*i +: 6]  = fn;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_grant(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant_timeout: req %0d got no grant, required one", i);
        end
    endtask

    task automatic do_reset();
        exp_q.delete();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        vt[0]  = '{0, 6'b010000, 32'd3,        32'd4,        32'd7,        1'b0};
        vt[1]  = '{1, 6'b010001, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0};
        vt[2]  = '{2, 6'b000000, 32'd12,       32'd34,       32'd0,        1'b1};
        vt[3]  = '{2, 6'b110010, 32'hFFFFFFFF, 32'd3,        32'd0,        1'b1};
        vt[4]  = '{3, 6'b000101, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
        vt[5]  = '{0, 6'b000011, 32'd9,        32'd9,        32'd1,        1'b0};
        vt[6]  = '{1, 6'b000111, 32'd5,        32'd4,        32'd0,        1'b0};
        vt[7]  = '{2, 6'b101000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        vt[8]  = '{3, 6'b101110, 32'h0000000F, 32'h00000030, 32'h0000003F, 1'b0};
        vt[9]  = '{0, 6'b100110, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
        vt[10] = '{1, 6'b110000, 32'd1,        32'd31,       32'h80000000, 1'b0};
        vt[11] = '{2, 6'b110001, 32'h80000000, 32'd4,        32'h08000000, 1'b0};
        vt[12] = '{3, 6'b110011, 32'h80000000, 32'd4,        32'hF8000000, 1'b0};
        vt[13] = '{0, 6'b010000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
        vt[14] = '{1, 6'b001001, 32'd7,        32'd8,        32'd0,        1'b1};

        // Reset state, with every requester asking
        req_valid = '1;
        rsp_ready = 1'b1;
        #12;
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_y", rsp_y, 32'd0);
        check("rst_id", {30'd0, rsp_id}, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Table: one requester at a time, result one cycle after grant
        for (int v = 0; v < 15; v++) begin
            drive(vt[v].id, vt[v].fn, vt[v].a, vt[v].b);
            wait_grant(vt[v].id, ok);
            tick();
            req_valid[vt[v].id] = 1'b0;
            if (ok) begin
                @(negedge clk);
                check("tbl_valid", {31'd0, rsp_valid}, 32'd1);
                check("tbl_y", rsp_y, vt[v].y);
                check("tbl_id", {30'd0, rsp_id}, vt[v].id);
                check("tbl_err", {31'd0, rsp_err}, {31'd0, vt[v].err});
                tick();
            end
        end

        // All requesters valid every cycle: grants rotate 0,1,2,3,0,...
        do_reset();
        gnt_log.delete();
        for (int i = 0; i < N; i++) begin
            drive(i, 6'b010000, 32'(i * 10), 32'(i));
        end
        repeat (8) @(negedge clk);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("rot_count", gnt_log.size(), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check("rot_order", (k < gnt_log.size()) ? gnt_log[k] : -1, k % 4);
        end
        tick();

        // Back-pressure: slot held, no grants, then drain and grant on the same edge
        drive(1, 6'b010001, 32'd5, 32'd7);
        wait_grant(1, ok);
        tick();
        req_valid[1] = 1'b0;
        rsp_ready = 1'b0;
        drive(2, 6'b010000, 32'd1, 32'd2);
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_y", rsp_y, 32'hFFFFFFFE);
            check("bp_id", {30'd0, rsp_id}, 32'd1);
            check("bp_ready", {28'd0, req_ready}, 32'd0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_gnt", {28'd0, req_ready}, 32'b0100);
        check("bp_old_y", rsp_y, 32'hFFFFFFFE);
        tick();
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("bp_new_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_new_y", rsp_y, 32'd3);
        check("bp_new_id", {30'd0, rsp_id}, 32'd2);
        tick();

        // Pointer now 3: lone req1 wins, then req0+req3 -> 3, then 0
        drive(1, 6'b101000, 32'hFFFF, 32'h00FF);
        @(negedge clk);
        check("rr_g1", {28'd0, req_ready}, 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        drive(0, 6'b010000, 32'd100, 32'd1);
        drive(3, 6'b110000, 32'd3, 32'd2);
        @(negedge clk);
        check("rr_g3", {28'd0, req_ready}, 32'b1000);
        tick();
        req_valid[3] = 1'b0;
        @(negedge clk);
        check("rr_g0", {28'd0, req_ready}, 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        tick();

        // Reset while a result is held and a request is pending
        rsp_ready = 1'b0;
        drive(0, 6'b010000, 32'd1, 32'd1);
        wait_grant(0, ok);
        tick();
        req_valid[0] = 1'b0;
        drive(2, 6'b100110, 32'hA5A5A5A5, 32'hFFFFFFFF);
        @(negedge clk);
        check("mr_pre_valid", {31'd0, rsp_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_valid", {31'd0, rsp_valid}, 32'd0);
        check("mr_y", rsp_y, 32'd0);
        check("mr_id", {30'd0, rsp_id}, 32'd0);
        check("mr_err", {31'd0, rsp_err}, 32'd0);
        check("mr_ready", {28'd0, req_ready}, 32'd0);
        exp_q.delete();
        drive(1, 6'b010000, 32'd20, 32'd22);
        drive(3, 6'b010001, 32'd9, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_gnt", {28'd0, req_ready}, 32'b0010);
        check("mr_no_rsp", {31'd0, rsp_valid}, 32'd0);
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;

        // Drain: every expected result must have come out
        repeat (3) @(negedge clk);
        check("end_queue", exp_q.size(), 32'd0);
        check("end_valid", {31'd0, rsp_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
